// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEF   = 10;
    localparam int unsigned LUT_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        JUMP = 2'd1,
        HOLD = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: one synchronous write port, one combinational read port.
// Entries have no reset; a same-index write and read return the old entry.
module jump_lut
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [LUT_AW-1:0] i_waddr,
    input  logic [PC_W-1:0]   i_wdata,
    input  logic [LUT_AW-1:0] i_raddr,
    output logic [PC_W-1:0]   o_rdata_c
);

    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic [PC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, next-PC priority mux, run/halt state machine and
// retired-instruction counter for the 8-bit single-cycle core.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned LUT_AW = LUT_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_op,
    input  logic              halt_op,
    input  logic              jen,
    input  logic              brc_j,
    input  logic [LUT_AW-1:0] tgt_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);

    pc_state_t        r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_retired;
    logic             r_running;
    logic             r_done;
    logic [PC_W-1:0]  w_tgt;
    pc_sel_t          w_sel;

    jump_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_jump_lut (
        .clk       (clk),
        .i_we      (lut_we),
        .i_waddr   (lut_waddr),
        .i_wdata   (lut_wdata),
        .i_raddr   (tgt_idx),
        .o_rdata_c (w_tgt)
    );

    // Next-PC source: halt beats jump beats taken branch beats sequential.
    always_comb begin
        w_sel = SEQ;
        if (halt_op) begin
            w_sel = HOLD;
        end else if (jen || (branch_op && !brc_j)) begin
            w_sel = JUMP;
        end
    end

    // start outranks stall and every next-PC source; reset outranks start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_retired <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_state   <= RUN;
            r_pc      <= '0;
            r_retired <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
        end else if (r_state == RUN && !stall) begin
            if (r_retired != {CNT_W{1'b1}}) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (w_sel)
                HOLD: begin
                    r_state   <= DONE;
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
                JUMP:    r_pc <= w_tgt;
                default: r_pc <= r_pc + PC_W'(1);
            endcase
        end
    end

    assign pc      = r_pc;
    assign running = r_running;
    assign done    = r_done;
    assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stall, branch_op, halt_op, jen, brc_j;
    logic [4:0]  tgt_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic [9:0]  pc;
    logic        running, done;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .branch_op (branch_op),
        .halt_op   (halt_op),
        .jen       (jen),
        .brc_j     (brc_j),
        .tgt_idx   (tgt_idx),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; branch_op = 0; halt_op = 0; jen = 0; brc_j = 0;
        tgt_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
        lut_we = 1; lut_waddr = a; lut_wdata = d;
        step();
        lut_we = 0;
    endtask

    task automatic jump(input logic [4:0] idx);
        jen = 1; tgt_idx = idx;
        step();
        jen = 0; tgt_idx = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step();
        reset = 0;
        chk("rst_pc", pc, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_retired", retired, 0);

        lut_write(5'd3, 10'h120);
        lut_write(5'd4, 10'h3FF);
        lut_write(5'd5, 10'h007);
        lut_write(5'd6, 10'h055);
        chk("idle_pc_held", pc, 0);

        // start, then five sequential instructions
        start = 1; step(); start = 0;
        chk("start_pc", pc, 0);
        chk("start_running", running, 1);
        chk("start_retired", retired, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("seq_pc%0d", i), pc, i);
        end
        chk("seq_retired", retired, 5);
        chk("seq_running", running, 1);

        step(); step();
        chk("pc7", pc, 7);

        // taken branch at pc 7
        branch_op = 1; brc_j = 0; tgt_idx = 3;
        step();
        branch_op = 0; tgt_idx = 0;
        chk("br_taken", pc, 10'h120);

        jump(5'd5);
        chk("jmp_to7", pc, 7);
        // branch not taken
        branch_op = 1; brc_j = 1; tgt_idx = 3;
        step();
        branch_op = 0; brc_j = 0; tgt_idx = 0;
        chk("br_not_taken", pc, 8);

        jump(5'd4);
        chk("jmp_3ff", pc, 10'h3FF);
        step();
        chk("pc_wrap", pc, 0);
        chk("retired_12", retired, 12);

        // halt outranks a simultaneous jump
        jen = 1; tgt_idx = 3; halt_op = 1;
        step();
        jen = 0; tgt_idx = 0; halt_op = 0;
        chk("halt_pc", pc, 0);
        chk("halt_done", done, 1);
        chk("halt_running", running, 0);
        chk("halt_retired", retired, 13);
        jump(5'd3);
        chk("done_pc_frozen", pc, 0);
        chk("done_retired_frozen", retired, 13);
        chk("done_still", done, 1);

        // restart from DONE
        start = 1; step(); start = 0;
        chk("restart_pc", pc, 0);
        chk("restart_done", done, 0);
        chk("restart_running", running, 1);
        chk("restart_retired", retired, 0);
        for (int i = 0; i < 4; i++) step();
        chk("pc4", pc, 4);

        // stall outranks halt and jump
        stall = 1; halt_op = 1; jen = 1; tgt_idx = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_pc%0d", i), pc, 4);
            chk($sformatf("stall_ret%0d", i), retired, 4);
            chk($sformatf("stall_run%0d", i), running, 1);
        end
        stall = 0; halt_op = 0; jen = 0; tgt_idx = 0;
        step();
        chk("unstall_pc", pc, 5);
        chk("unstall_retired", retired, 5);

        // reset mid-run beats start
        jump(5'd6);
        chk("pc55", pc, 10'h055);
        reset = 1; start = 1;
        step();
        reset = 0; start = 0;
        chk("midrst_pc", pc, 0);
        chk("midrst_running", running, 0);
        chk("midrst_done", done, 0);
        chk("midrst_retired", retired, 0);
        step();
        chk("midrst_idle_pc", pc, 0);

        // table survives reset
        start = 1; step(); start = 0;
        jump(5'd3);
        chk("lut_kept", pc, 10'h120);

        // same-cycle write and read returns the old entry
        lut_we = 1; lut_waddr = 3; lut_wdata = 10'h200; jen = 1; tgt_idx = 3;
        step();
        lut_we = 0; jen = 0; tgt_idx = 0;
        chk("wr_rd_old", pc, 10'h120);
        jump(5'd3);
        chk("wr_rd_new", pc, 10'h200);
        chk("retired_3", retired, 3);

        // start outranks stall in RUN
        start = 1; stall = 1;
        step();
        start = 0; stall = 0;
        chk("start_over_stall_pc", pc, 0);
        chk("start_over_stall_ret", retired, 0);
        chk("start_over_stall_run", running, 1);

        // brc_j alone is ignored without branch_op
        step();
        brc_j = 0; tgt_idx = 3;
        step();
        tgt_idx = 0;
        chk("brc_no_decode", pc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
